// File: rtl/elevator.sv
// Four-floor collective-control elevator: buttons are latched until served, and the car sweeps one way before it reverses.
// DISP lags the floor sensors by one cycle, AC and Open decode the state register, and there is no backpressure (every press is held).
module elevator #(
   parameter int DOOR_CYCLES = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       F1,
   input  logic       F2,
   input  logic       F3,
   input  logic       F4,
   input  logic       U1,
   input  logic       U2,
   input  logic       U3,
   input  logic       U4,
   input  logic       D1,
   input  logic       D2,
   input  logic       D3,
   input  logic       D4,
   input  logic       S1,
   input  logic       S2,
   input  logic       S3,
   input  logic       S4,
   output logic [1:0] AC,
   output logic [2:0] DISP,
   output logic       Open
);

   localparam int CW = $clog2(DOOR_CYCLES + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_UP   = 2'd1;
   localparam logic [1:0] ST_DOWN = 2'd2;
   localparam logic [1:0] ST_DOOR = 2'd3;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   logic [1:0]    state, state_n;
   logic          dir, dir_n;
   logic [2:0]    floor, last_floor, floor_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [3:0]    cab_req, up_req, dn_req;

   logic [3:0] f_in, u_in, d_in, s_in;
   logic [3:0] here, above, below, any_req;
   logic [3:0] hall_dir, hall_opp, clr_opp;
   logic [3:0] clr_cab, clr_up, clr_dn;
   logic       req_above, req_below, beyond, serve_here, new_floor, reload;

   assign f_in = {F4, F3, F2, F1};
   assign u_in = {U4, U3, U2, U1};
   assign d_in = {D4, D3, D2, D1};
   assign s_in = {S4, S3, S2, S1};

   always_comb begin
      here  = '0;
      above = '0;
      below = '0;
      for (int k = 0; k < 4; k++) begin
         here[k]  = (floor == 3'(k + 1));
         above[k] = (3'(k + 1) > floor);
         below[k] = (3'(k + 1) < floor);
      end
   end

   assign any_req   = cab_req | up_req | dn_req;
   assign req_above = |(any_req & above);
   assign req_below = |(any_req & below);
   assign new_floor = (floor != last_floor);

   assign hall_dir = (dir == DIR_UP) ? up_req : dn_req;
   assign hall_opp = (dir == DIR_UP) ? dn_req : up_req;
   assign beyond   = (dir == DIR_UP) ? req_above : req_below;
   assign clr_opp  = beyond ? 4'b0000 : here;

   // An opposite-direction hall call is answered on the return sweep; opening
   // for it now would leave it latched and cycle the door forever.
   assign serve_here = |(here & (cab_req | hall_dir | (hall_opp & clr_opp)));

   always_comb begin
      clr_cab = '0;
      clr_up  = '0;
      clr_dn  = '0;
      if (state == ST_DOOR) begin
         clr_cab = here;
         if (dir == DIR_UP) begin
            clr_up = here;
            clr_dn = clr_opp;
         end else begin
            clr_dn = here;
            clr_up = clr_opp;
         end
      end
   end

   assign reload = |((f_in & clr_cab) | (u_in & clr_up) | (d_in & clr_dn));

   always_comb begin
      floor_n = floor;
      if (s_in[0])      floor_n = 3'd1;
      else if (s_in[1]) floor_n = 3'd2;
      else if (s_in[2]) floor_n = 3'd3;
      else if (s_in[3]) floor_n = 3'd4;
   end

   always_comb begin
      state_n = state;
      dir_n   = dir;
      cnt_n   = cnt;
      case (state)
         ST_IDLE: begin
            if (floor != 3'd0) begin
               if (serve_here) begin
                  state_n = ST_DOOR;
                  cnt_n   = CW'(DOOR_CYCLES);
               end else if (dir == DIR_UP) begin
                  if (req_above) begin
                     state_n = ST_UP;
                  end else if (req_below) begin
                     state_n = ST_DOWN;
                     dir_n   = DIR_DOWN;
                  end
               end else begin
                  if (req_below) begin
                     state_n = ST_DOWN;
                  end else if (req_above) begin
                     state_n = ST_UP;
                     dir_n   = DIR_UP;
                  end
               end
            end
         end
         ST_UP: begin
            if (new_floor && ((|(here & (cab_req | up_req))) || !req_above || floor == 3'd4)) begin
               state_n = ST_DOOR;
               cnt_n   = CW'(DOOR_CYCLES);
            end
         end
         ST_DOWN: begin
            if (new_floor && ((|(here & (cab_req | dn_req))) || !req_below || floor == 3'd1)) begin
               state_n = ST_DOOR;
               cnt_n   = CW'(DOOR_CYCLES);
            end
         end
         ST_DOOR: begin
            if (reload) begin
               cnt_n = CW'(DOOR_CYCLES);
            end else if (cnt <= CW'(1)) begin
               state_n = ST_IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         default: begin
            state_n = ST_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= ST_IDLE;
         dir        <= DIR_UP;
         floor      <= 3'd0;
         last_floor <= 3'd0;
         cnt        <= '0;
         cab_req    <= '0;
         up_req     <= '0;
         dn_req     <= '0;
      end else begin
         state      <= state_n;
         dir        <= dir_n;
         floor      <= floor_n;
         last_floor <= floor;
         cnt        <= cnt_n;
         // Clearing at the served floor beats a same-cycle press there.
         cab_req    <= (cab_req | f_in) & ~clr_cab;
         up_req     <= (up_req | u_in) & ~clr_up;
         dn_req     <= (dn_req | d_in) & ~clr_dn;
      end
   end

   always_comb begin
      case (state)
         ST_UP:   AC = 2'b01;
         ST_DOWN: AC = 2'b10;
         default: AC = 2'b00;
      endcase
   end

   assign Open = (state == ST_DOOR);
   assign DISP = floor;

endmodule

// File: tb/tb_elevator.sv
// Cycle-by-cycle bench for the elevator: table of inputs and expected outputs plus a few hand-written sequences.
module tb_elevator;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [3:0] f, u, d, s;
   logic [1:0] AC;
   logic [2:0] DISP;
   logic       Open;

   elevator #(.DOOR_CYCLES(4)) dut (
      .CLK(CLK), .RESET(RESET),
      .F1(f[0]), .F2(f[1]), .F3(f[2]), .F4(f[3]),
      .U1(u[0]), .U2(u[1]), .U3(u[2]), .U4(u[3]),
      .D1(d[0]), .D2(d[1]), .D3(d[2]), .D4(d[3]),
      .S1(s[0]), .S2(s[1]), .S3(s[2]), .S4(s[3]),
      .AC(AC), .DISP(DISP), .Open(Open)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic       rst;
      logic [3:0] f, u, d, s;
      logic [1:0] ac;
      logic [2:0] disp;
      logic       open;
   } vec_t;

   typedef struct {
      logic [1:0] ac;
      logic [2:0] disp;
      logic       open;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   int   checks = 0;
   int   passes = 0;

   function automatic vec_t mk(input logic rst, input logic [3:0] fi, ui, di, si,
                               input logic [1:0] ac, input logic [2:0] disp, input logic op);
      vec_t v;
      v.rst = rst; v.f = fi; v.u = ui; v.d = di; v.s = si;
      v.ac = ac; v.disp = disp; v.open = op;
      return v;
   endfunction

   task automatic rep(input int n, input vec_t v);
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   task automatic step(input vec_t v, input string tag, input int idx);
      exp_t e;
      RESET = v.rst; f = v.f; u = v.u; d = v.d; s = v.s;
      e.ac = v.ac; e.disp = v.disp; e.open = v.open;
      exp_q.push_back(e);
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({AC, DISP, Open} === {e.ac, e.disp, e.open}) passes++;
      else $display("FAIL %s[%0d] ac/disp/open got %b/%0d/%b want %b/%0d/%b",
                    tag, idx, AC, DISP, Open, e.ac, e.disp, e.open);
      checks++;
      if (!(Open !== 1'b0 && AC !== 2'b00)) passes++;
      else $display("FAIL %s[%0d] exclusive ac=%b open=%b want ac=00 when open", tag, idx, AC, Open);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      // reset held with U1 pressed and the car at floor 1
      rep(3, mk(1, 4'h0, 4'h1, 4'h0, 4'h1, 2'b00, 3'd0, 0));
      // release; U1 during reset must not have latched
      rep(3, mk(0, 4'h0, 4'h0, 4'h0, 4'h1, 2'b00, 3'd1, 0));
      // U1 at floor 1: door opens for 4 cycles
      rep(1, mk(0, 4'h0, 4'h1, 4'h0, 4'h1, 2'b00, 3'd1, 0));
      rep(4, mk(0, 4'h0, 4'h0, 4'h0, 4'h1, 2'b00, 3'd1, 1));
      rep(2, mk(0, 4'h0, 4'h0, 4'h0, 4'h1, 2'b00, 3'd1, 0));
      // F4 from floor 1: travel through 2 and 3 with gaps, stop at 4
      rep(1, mk(0, 4'h8, 4'h0, 4'h0, 4'h1, 2'b00, 3'd1, 0));
      rep(2, mk(0, 4'h0, 4'h0, 4'h0, 4'h1, 2'b01, 3'd1, 0));
      rep(1, mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b01, 3'd1, 0));
      rep(2, mk(0, 4'h0, 4'h0, 4'h0, 4'h2, 2'b01, 3'd2, 0));
      rep(1, mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b01, 3'd2, 0));
      rep(2, mk(0, 4'h0, 4'h0, 4'h0, 4'h4, 2'b01, 3'd3, 0));
      rep(1, mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b01, 3'd3, 0));
      rep(1, mk(0, 4'h0, 4'h0, 4'h0, 4'h8, 2'b01, 3'd4, 0));
      rep(4, mk(0, 4'h0, 4'h0, 4'h0, 4'h8, 2'b00, 3'd4, 1));
      rep(2, mk(0, 4'h0, 4'h0, 4'h0, 4'h8, 2'b00, 3'd4, 0));
      // from 4: D2 and U3; passes 3 going down, serves 2, reverses to 3
      rep(1, mk(0, 4'h0, 4'h4, 4'h2, 4'h8, 2'b00, 3'd4, 0));
      rep(2, mk(0, 4'h0, 4'h0, 4'h0, 4'h8, 2'b10, 3'd4, 0));
      rep(1, mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b10, 3'd4, 0));
      rep(2, mk(0, 4'h0, 4'h0, 4'h0, 4'h4, 2'b10, 3'd3, 0));
      rep(1, mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b10, 3'd3, 0));
      rep(1, mk(0, 4'h0, 4'h0, 4'h0, 4'h2, 2'b10, 3'd2, 0));
      rep(4, mk(0, 4'h0, 4'h0, 4'h0, 4'h2, 2'b00, 3'd2, 1));
      rep(1, mk(0, 4'h0, 4'h0, 4'h0, 4'h2, 2'b00, 3'd2, 0));
      rep(2, mk(0, 4'h0, 4'h0, 4'h0, 4'h2, 2'b01, 3'd2, 0));
      rep(1, mk(0, 4'h0, 4'h0, 4'h0, 4'h4, 2'b01, 3'd3, 0));
      rep(4, mk(0, 4'h0, 4'h0, 4'h0, 4'h4, 2'b00, 3'd3, 1));
      rep(2, mk(0, 4'h0, 4'h0, 4'h0, 4'h4, 2'b00, 3'd3, 0));
      // F1 from 3: back down to floor 1
      rep(1, mk(0, 4'h1, 4'h0, 4'h0, 4'h4, 2'b00, 3'd3, 0));
      rep(1, mk(0, 4'h0, 4'h0, 4'h0, 4'h4, 2'b10, 3'd3, 0));
      rep(1, mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b10, 3'd3, 0));
      rep(2, mk(0, 4'h0, 4'h0, 4'h0, 4'h2, 2'b10, 3'd2, 0));
      rep(1, mk(0, 4'h0, 4'h0, 4'h0, 4'h1, 2'b10, 3'd1, 0));
      rep(4, mk(0, 4'h0, 4'h0, 4'h0, 4'h1, 2'b00, 3'd1, 1));
      rep(2, mk(0, 4'h0, 4'h0, 4'h0, 4'h1, 2'b00, 3'd1, 0));
      // F4 and U3 together from 1: stop at 3, then continue to 4
      rep(1, mk(0, 4'h8, 4'h4, 4'h0, 4'h1, 2'b00, 3'd1, 0));
      rep(1, mk(0, 4'h0, 4'h0, 4'h0, 4'h1, 2'b01, 3'd1, 0));
      rep(1, mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b01, 3'd1, 0));
      rep(2, mk(0, 4'h0, 4'h0, 4'h0, 4'h2, 2'b01, 3'd2, 0));
      rep(1, mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b01, 3'd2, 0));
      rep(1, mk(0, 4'h0, 4'h0, 4'h0, 4'h4, 2'b01, 3'd3, 0));
      rep(4, mk(0, 4'h0, 4'h0, 4'h0, 4'h4, 2'b00, 3'd3, 1));
      rep(1, mk(0, 4'h0, 4'h0, 4'h0, 4'h4, 2'b00, 3'd3, 0));
      rep(1, mk(0, 4'h0, 4'h0, 4'h0, 4'h4, 2'b01, 3'd3, 0));
      rep(1, mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b01, 3'd3, 0));
      rep(1, mk(0, 4'h0, 4'h0, 4'h0, 4'h8, 2'b01, 3'd4, 0));
      rep(4, mk(0, 4'h0, 4'h0, 4'h0, 4'h8, 2'b00, 3'd4, 1));
      rep(2, mk(0, 4'h0, 4'h0, 4'h0, 4'h8, 2'b00, 3'd4, 0));

      for (int i = 0; i < vecs.size(); i++) step(vecs[i], "table", i);

      // re-press of F4 while the door is open at 4 reloads the counter and is not kept
      step(mk(0, 4'h8, 4'h0, 4'h0, 4'h8, 2'b00, 3'd4, 0), "reload", 0);
      step(mk(0, 4'h0, 4'h0, 4'h0, 4'h8, 2'b00, 3'd4, 1), "reload", 1);
      step(mk(0, 4'h0, 4'h0, 4'h0, 4'h8, 2'b00, 3'd4, 1), "reload", 2);
      step(mk(0, 4'h8, 4'h0, 4'h0, 4'h8, 2'b00, 3'd4, 1), "reload", 3);
      for (int i = 4; i < 7; i++)
         step(mk(0, 4'h0, 4'h0, 4'h0, 4'h8, 2'b00, 3'd4, 1), "reload", i);
      step(mk(0, 4'h0, 4'h0, 4'h0, 4'h8, 2'b00, 3'd4, 0), "reload", 7);
      step(mk(0, 4'h0, 4'h0, 4'h0, 4'h8, 2'b00, 3'd4, 0), "reload", 8);

      // reset while moving down aborts, clears the F1 request, then lowest sensor wins
      step(mk(0, 4'h1, 4'h0, 4'h0, 4'h8, 2'b00, 3'd4, 0), "rstmove", 0);
      step(mk(0, 4'h0, 4'h0, 4'h0, 4'h8, 2'b10, 3'd4, 0), "rstmove", 1);
      step(mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b10, 3'd4, 0), "rstmove", 2);
      step(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 2'b00, 3'd0, 0), "rstmove", 3);
      step(mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b00, 3'd0, 0), "rstmove", 4);
      step(mk(0, 4'h0, 4'h0, 4'h0, 4'h4, 2'b00, 3'd3, 0), "rstmove", 5);
      step(mk(0, 4'h0, 4'h0, 4'h0, 4'h4, 2'b00, 3'd3, 0), "rstmove", 6);
      step(mk(0, 4'h0, 4'h0, 4'h0, 4'hC, 2'b00, 3'd3, 0), "rstmove", 7);
      step(mk(0, 4'h0, 4'h0, 4'h0, 4'h6, 2'b00, 3'd2, 0), "rstmove", 8);
      step(mk(0, 4'h0, 4'h0, 4'h0, 4'h6, 2'b00, 3'd2, 0), "rstmove", 9);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
